// File: rtl/reram_wb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_REQ masters share one ReRAM slave, one single-beat transfer per grant.
// Optional slave-timeout abort is enabled by defining RERAM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant; pick the next requester round-robin after r_last
// BUSY  | granted master's signals muxed to the slave; wait for ack / cyc drop / timeout
// GAP   | one dead cycle with all slave controls low so the slave can drop its ack
module reram_wb_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic [NUM_REQ-1:0]     m_cyc_i,
   input  logic [NUM_REQ-1:0]     m_stb_i,
   input  logic [NUM_REQ-1:0]     m_we_i,
   input  logic [4*NUM_REQ-1:0]   m_sel_i,
   input  logic [32*NUM_REQ-1:0]  m_adr_i,
   input  logic [32*NUM_REQ-1:0]  m_dat_i,
   output logic [NUM_REQ-1:0]     m_ack_o,
   output logic [NUM_REQ-1:0]     m_err_o,
   output logic [31:0]            m_dat_o,
   output logic                   s_cyc_o,
   output logic                   s_stb_o,
   output logic                   s_we_o,
   output logic [3:0]             s_sel_o,
   output logic [31:0]            s_adr_o,
   output logic [31:0]            s_dat_o,
   input  logic                   s_ack_i,
   input  logic [31:0]            s_dat_i,
   output logic [NUM_REQ-1:0]     grant_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
   logic [IDX_W-1:0]   r_gidx, w_gidx_nxt;
   logic [IDX_W-1:0]   r_last, w_last_nxt;
   logic [NUM_REQ-1:0] w_req;
   logic [IDX_W-1:0]   w_win_idx;
   logic               w_win_vld;
   logic               w_g_cyc;
   logic               w_g_stb;
   logic               w_ack_g;
   logic               w_tmo;

   assign w_req   = m_cyc_i & m_stb_i;
   assign w_g_cyc = m_cyc_i[r_gidx];
   assign w_g_stb = m_stb_i[r_gidx];
   assign w_ack_g = (r_state == ST_BUSY) && w_g_cyc && s_ack_i;

   // Search starts one past the last completed grant, wrapping around.
   always_comb begin
      w_win_vld = 1'b0;
      w_win_idx = r_last;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!w_win_vld && w_req[IDX_W'((int'(r_last) + i) % NUM_REQ)]) begin
            w_win_vld = 1'b1;
            w_win_idx = IDX_W'((int'(r_last) + i) % NUM_REQ);
         end
      end
   end

`ifdef RERAM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] r_tmo_cnt;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_tmo_cnt <= '0;
      end else if (r_state != ST_BUSY) begin
         r_tmo_cnt <= '0;
      end else if (!s_ack_i) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   assign w_tmo = (r_state == ST_BUSY) && w_g_cyc && !s_ack_i &&
                  (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_tmo;
   assign w_unused_tmo = ^TIMEOUT_CYCLES;
   assign w_tmo        = 1'b0;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_gidx  <= '0;
         r_last  <= IDX_W'(NUM_REQ - 1);
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_gidx  <= w_gidx_nxt;
         r_last  <= w_last_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_gidx_nxt  = r_gidx;
      w_last_nxt  = r_last;
      case (r_state)
         ST_IDLE: begin
            if (w_win_vld) begin
               w_state_nxt            = ST_BUSY;
               w_grant_nxt            = '0;
               w_grant_nxt[w_win_idx] = 1'b1;
               w_gidx_nxt             = w_win_idx;
            end
         end
         ST_BUSY: begin
            // A master dropping cyc abandons the transfer without moving the round-robin pointer.
            if (!w_g_cyc) begin
               w_state_nxt = ST_GAP;
               w_grant_nxt = '0;
            end else if (s_ack_i || w_tmo) begin
               w_state_nxt = ST_GAP;
               w_grant_nxt = '0;
               w_last_nxt  = r_gidx;
            end
         end
         ST_GAP: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_adr_o = '0;
      s_dat_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      m_dat_o = '0;
      if (r_state == ST_BUSY) begin
         s_cyc_o = w_g_cyc;
         s_stb_o = w_g_cyc && w_g_stb;
         s_we_o  = m_we_i[r_gidx];
         s_sel_o = m_sel_i[4*r_gidx +: 4];
         s_adr_o = m_adr_i[32*r_gidx +: 32];
         s_dat_o = m_dat_i[32*r_gidx +: 32];
         m_dat_o = s_dat_i;
         if (w_ack_g) begin
            m_ack_o[r_gidx] = 1'b1;
         end else if (w_tmo) begin
            m_err_o[r_gidx] = 1'b1;
         end
      end
   end

   assign grant_o = r_grant;

endmodule

// File: tb/tb_reram_wb_arbiter.sv
// Directed bench for reram_wb_arbiter (two masters, TIMEOUT_CYCLES=16).
// Covers both builds: with and without RERAM_ARB_TIMEOUT_EN.
module tb_reram_wb_arbiter;
   localparam int NR  = 2;
   localparam int TMO = 16;

   logic              wb_clk_i = 1'b0;
   logic              wb_rst_i;
   logic [NR-1:0]     m_cyc_i, m_stb_i, m_we_i;
   logic [4*NR-1:0]   m_sel_i;
   logic [32*NR-1:0]  m_adr_i, m_dat_i;
   logic [NR-1:0]     m_ack_o, m_err_o;
   logic [31:0]       m_dat_o;
   logic              s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]        s_sel_o;
   logic [31:0]       s_adr_o, s_dat_o;
   logic              s_ack_i;
   logic [31:0]       s_dat_i;
   logic [NR-1:0]     grant_o;

   int n_checks = 0;
   int n_errors = 0;

   reram_wb_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .grant_o(grant_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic step();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      wb_rst_i = 1'b1;
      m_cyc_i  = '0;
      m_stb_i  = '0;
      m_we_i   = '0;
      m_sel_i  = '0;
      m_adr_i  = '0;
      m_dat_i  = '0;
      s_ack_i  = 1'b0;
      s_dat_i  = '0;

      step();
      step();
      settle();
      check("rst_grant", 32'(grant_o), 32'h0);
      check("rst_stb",   32'(s_stb_o), 32'h0);
      check("rst_cyc",   32'(s_cyc_o), 32'h0);
      check("rst_ack",   32'(m_ack_o), 32'h0);
      check("rst_err",   32'(m_err_o), 32'h0);
      check("rst_dat",   m_dat_o,      32'h0);
      wb_rst_i = 1'b0;

      // single write from master 0, slave acks two cycles after stb
      m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b01;
      m_sel_i[3:0] = 4'hF; m_adr_i[31:0] = 32'h3000_0004; m_dat_i[31:0] = 32'hA5A5_5A5A;
      settle();
      check("t1_c0_stb", 32'(s_stb_o), 32'h0);
      step(); settle();
      check("t1_c1_stb",   32'(s_stb_o), 32'h1);
      check("t1_c1_cyc",   32'(s_cyc_o), 32'h1);
      check("t1_c1_adr",   s_adr_o,      32'h3000_0004);
      check("t1_c1_dat",   s_dat_o,      32'hA5A5_5A5A);
      check("t1_c1_sel",   32'(s_sel_o), 32'hF);
      check("t1_c1_we",    32'(s_we_o),  32'h1);
      check("t1_c1_grant", 32'(grant_o), 32'h1);
      check("t1_c1_ack",   32'(m_ack_o), 32'h0);
      step(); settle();
      check("t1_c2_ack", 32'(m_ack_o), 32'h0);
      step(); s_ack_i = 1'b1; settle();
      check("t1_c3_ack", 32'(m_ack_o), 32'h1);
      step(); m_cyc_i = '0; m_stb_i = '0; settle();
      check("t1_gap_stray_ack", 32'(m_ack_o), 32'h0);
      check("t1_gap_grant",     32'(grant_o), 32'h0);
      check("t1_gap_stb",       32'(s_stb_o), 32'h0);
      step(); s_ack_i = 1'b0; settle();
      check("t1_idle_grant", 32'(grant_o), 32'h0);

      // reset during the second BUSY cycle of a master 1 transfer
      m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b00; m_adr_i[63:32] = 32'h3000_0020;
      step(); settle();
      check("t4_grant_m1", 32'(grant_o), 32'h2);
      step(); settle();
      check("t4_busy2_ack", 32'(m_ack_o), 32'h0);
      wb_rst_i = 1'b1;
      step(); s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF; settle();
      check("t4_rst_stb",   32'(s_stb_o), 32'h0);
      check("t4_rst_cyc",   32'(s_cyc_o), 32'h0);
      check("t4_rst_grant", 32'(grant_o), 32'h0);
      check("t4_rst_ack",   32'(m_ack_o), 32'h0);
      check("t4_rst_adr",   s_adr_o,      32'h0);
      check("t4_rst_dat",   m_dat_o,      32'h0);
      wb_rst_i = 1'b0; s_ack_i = 1'b0; m_cyc_i = 2'b11; m_stb_i = 2'b11;
      step(); settle();
      check("t4_post_grant", 32'(grant_o), 32'h1);
      s_ack_i = 1'b1; settle();
      check("t4_post_ack", 32'(m_ack_o), 32'h1);
      step(); s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0; settle();
      check("t4_gap_grant", 32'(grant_o), 32'h0);
      step();

      // master 1 read with same-cycle ack and data
      m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b00; m_adr_i[63:32] = 32'h3000_0010;
      step(); s_ack_i = 1'b1; s_dat_i = 32'h1234_5678; settle();
      check("t3_adr",  s_adr_o,      32'h3000_0010);
      check("t3_we",   32'(s_we_o),  32'h0);
      check("t3_rdat", m_dat_o,      32'h1234_5678);
      check("t3_ack",  32'(m_ack_o), 32'h2);
      step(); s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0; settle();
      check("t3_gap_grant", 32'(grant_o), 32'h0);
      step();

      // both masters request continuously; expect 0,1,0,1
      m_adr_i[31:0] = 32'h0000_0100; m_adr_i[63:32] = 32'h0000_0200;
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      for (int t = 0; t < 4; t++) begin
         step(); settle();
         check("t2_grant",    32'(grant_o), (t % 2 == 0) ? 32'h1 : 32'h2);
         check("t2_adr",      s_adr_o,      (t % 2 == 0) ? 32'h100 : 32'h200);
         check("t2_stb",      32'(s_stb_o), 32'h1);
         check("t2_early_ack", 32'(m_ack_o), 32'h0);
         step(); s_ack_i = 1'b1; settle();
         check("t2_ack", 32'(m_ack_o), (t % 2 == 0) ? 32'h1 : 32'h2);
         step(); s_ack_i = 1'b0; settle();
         check("t2_gap_stb",   32'(s_stb_o), 32'h0);
         check("t2_gap_grant", 32'(grant_o), 32'h0);
         step(); settle();
         check("t2_idle_grant", 32'(grant_o), 32'h0);
      end

      // granted master 0 drops cyc; pending master 1 follows
      step(); settle();
      check("t6_grant_m0", 32'(grant_o), 32'h1);
      step(); m_cyc_i = 2'b10; m_stb_i = 2'b10; settle();
      check("t6_drop_cyc", 32'(s_cyc_o), 32'h0);
      check("t6_drop_stb", 32'(s_stb_o), 32'h0);
      check("t6_drop_ack", 32'(m_ack_o), 32'h0);
      check("t6_drop_err", 32'(m_err_o), 32'h0);
      step(); settle();
      check("t6_gap_grant", 32'(grant_o), 32'h0);
      check("t6_gap_ack",   32'(m_ack_o), 32'h0);
      step(); settle();
      step(); settle();
      check("t6_grant_m1", 32'(grant_o), 32'h2);
      s_ack_i = 1'b1; settle();
      check("t6_ack_m1", 32'(m_ack_o), 32'h2);
      step(); s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
      step();

      // slave never acks master 0 while master 1 waits
      m_adr_i[31:0] = 32'h3000_0040; m_cyc_i = 2'b11; m_stb_i = 2'b11;
      step();
`ifdef RERAM_ARB_TIMEOUT_EN
      for (int c = 1; c <= TMO; c++) begin
         if (c > 1) step();
         settle();
         check("t5_err", 32'(m_err_o), (c == TMO) ? 32'h1 : 32'h0);
         check("t5_stb", 32'(s_stb_o), 32'h1);
      end
      step(); settle();
      check("t5_gap_stb",   32'(s_stb_o), 32'h0);
      check("t5_gap_err",   32'(m_err_o), 32'h0);
      check("t5_gap_grant", 32'(grant_o), 32'h0);
      step(); settle();
      step(); settle();
`else
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) step();
         settle();
         check("t5_hold_stb",   32'(s_stb_o), 32'h1);
         check("t5_hold_err",   32'(m_err_o), 32'h0);
         check("t5_hold_grant", 32'(grant_o), 32'h1);
      end
      m_cyc_i = 2'b10; m_stb_i = 2'b10;
      step(); settle();
      check("t5_gap_grant", 32'(grant_o), 32'h0);
      step(); settle();
      step(); settle();
`endif
      check("t5_next_grant", 32'(grant_o), 32'h2);
      s_ack_i = 1'b1; settle();
      check("t5_next_ack", 32'(m_ack_o), 32'h2);
      step(); s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
